// File: rtl/insertion_sort_ctrl.sv
// Control FSM for the insertion-sort engine: sequences the outer/inner sort
// loops, drives all datapath strobes and owns the AR/R and AW/W/B handshake timing.
module insertion_sort_ctrl #(
    parameter int RESP_WDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic                 elem2insert_gt_elem2compare,
    input  logic                 j_gte_0,
    input  logic                 i_lt_arr_size,
    output logic                 sl_1_incd_to_i,
    output logic                 ld_i,
    output logic                 sl_i_minus_1_decrd_to_j,
    output logic                 ld_j,
    output logic                 ld_elem2insert,
    output logic                 ld_elem2compare,
    output logic                 sl_i_j_to_arg_read_addr,
    output logic                 ld_arg_read_addr,
    output logic                 sl_j_j_plus_1_to_arg_write_addr,
    output logic                 ld_arg_write_addr,
    output logic                 sl_elem2insert_elem2compare_to_arg_write_data,
    output logic                 ld_arg_write_data,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    input  logic                 r_valid,
    output logic                 r_ready,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic                 w_valid,
    input  logic                 w_ready,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RESP_WDTH-1:0] b_resp
);

    typedef enum logic [4:0] {
        S_IDLE, S_INIT, S_CHK_I, S_KEY_SET, S_KEY_AR, S_KEY_R, S_CHK_J,
        S_CMP_SET, S_CMP_AR, S_CMP_R, S_CMP, S_SH_SET, S_SH_WR, S_SH_B,
        S_DEC_J, S_INS_SET, S_INS_WR, S_INS_B, S_INC_I, S_DONE, S_ERROR
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_aw_done;
    logic   r_w_done;
    logic   w_in_wr;
    logic   w_aw_hs;
    logic   w_w_hs;
    logic   w_wr_complete;

    // AW and W are tracked separately so each valid can drop on its own handshake.
    assign w_in_wr       = (r_state == S_SH_WR) || (r_state == S_INS_WR);
    assign w_aw_hs       = w_in_wr && !r_aw_done && aw_ready;
    assign w_w_hs        = w_in_wr && !r_w_done && w_ready;
    assign w_wr_complete = w_in_wr && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_aw_done <= w_in_wr && !w_wr_complete && (r_aw_done || w_aw_hs);
            r_w_done  <= w_in_wr && !w_wr_complete && (r_w_done || w_w_hs);
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next                                        = r_state;
        done                                          = 1'b0;
        error                                         = 1'b0;
        sl_1_incd_to_i                                = 1'b0;
        ld_i                                          = 1'b0;
        sl_i_minus_1_decrd_to_j                       = 1'b0;
        ld_j                                          = 1'b0;
        ld_elem2insert                                = 1'b0;
        ld_elem2compare                               = 1'b0;
        sl_i_j_to_arg_read_addr                       = 1'b0;
        ld_arg_read_addr                              = 1'b0;
        sl_j_j_plus_1_to_arg_write_addr               = 1'b0;
        ld_arg_write_addr                             = 1'b0;
        sl_elem2insert_elem2compare_to_arg_write_data = 1'b0;
        ld_arg_write_data                             = 1'b0;
        ar_valid                                      = 1'b0;
        r_ready                                       = 1'b0;
        aw_valid                                      = 1'b0;
        w_valid                                       = 1'b0;
        b_ready                                       = 1'b0;

        case (r_state)
            S_IDLE: if (start) w_next = S_INIT;
            S_INIT: begin
                ld_i           = 1'b1;
                sl_1_incd_to_i = 1'b1;
                w_next         = S_CHK_I;
            end
            S_CHK_I: w_next = i_lt_arr_size ? S_KEY_SET : S_DONE;
            S_KEY_SET: begin
                ld_arg_read_addr        = 1'b1;
                sl_i_j_to_arg_read_addr = 1'b1;
                ld_j                    = 1'b1;
                sl_i_minus_1_decrd_to_j = 1'b1;
                w_next                  = S_KEY_AR;
            end
            S_KEY_AR: begin
                ar_valid = 1'b1;
                if (ar_ready) w_next = S_KEY_R;
            end
            S_KEY_R: begin
                r_ready        = 1'b1;
                ld_elem2insert = r_valid;
                if (r_valid) w_next = S_CHK_J;
            end
            S_CHK_J: w_next = j_gte_0 ? S_CMP_SET : S_INS_SET;
            S_CMP_SET: begin
                ld_arg_read_addr = 1'b1;
                w_next           = S_CMP_AR;
            end
            S_CMP_AR: begin
                ar_valid = 1'b1;
                if (ar_ready) w_next = S_CMP_R;
            end
            S_CMP_R: begin
                r_ready         = 1'b1;
                ld_elem2compare = r_valid;
                if (r_valid) w_next = S_CMP;
            end
            S_CMP: w_next = elem2insert_gt_elem2compare ? S_INS_SET : S_SH_SET;
            S_SH_SET: begin
                ld_arg_write_addr = 1'b1;
                ld_arg_write_data = 1'b1;
                w_next            = S_SH_WR;
            end
            S_SH_WR: begin
                aw_valid = !r_aw_done;
                w_valid  = !r_w_done;
                if (w_wr_complete) w_next = S_SH_B;
            end
            S_SH_B: begin
                b_ready = 1'b1;
                if (b_valid) w_next = (|b_resp) ? S_ERROR : S_DEC_J;
            end
            S_DEC_J: begin
                ld_j   = 1'b1;
                w_next = S_CHK_J;
            end
            S_INS_SET: begin
                ld_arg_write_addr                             = 1'b1;
                ld_arg_write_data                             = 1'b1;
                sl_elem2insert_elem2compare_to_arg_write_data = 1'b1;
                w_next                                        = S_INS_WR;
            end
            S_INS_WR: begin
                aw_valid = !r_aw_done;
                w_valid  = !r_w_done;
                if (w_wr_complete) w_next = S_INS_B;
            end
            S_INS_B: begin
                b_ready = 1'b1;
                if (b_valid) w_next = (|b_resp) ? S_ERROR : S_INC_I;
            end
            S_INC_I: begin
                ld_i   = 1'b1;
                w_next = S_CHK_I;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERROR: error = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);

endmodule
